johnson_seq_ctrl: RTL and testbench

Controller that owns and sequences a WIDTH-bit Johnson ring (2·WIDTH phases) of the kind built from the team's dff chain. It accepts run commands with a programmable advance count, single-step, stop, direction and preset, and decodes the ring into a one-hot phase bus. It also detects and recovers from illegal ring patterns. It sits between a host/sequencer issuing commands and downstream logic consuming phase strobes.

---
 rtl/johnson_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_johnson_seq_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_seq_ctrl.sv
// Sequencer for a WIDTH-bit Johnson ring: counted/free runs, single step, preset,
// one-hot phase decode and recovery from illegal ring patterns.
module johnson_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   len,
  input  logic               dir,
  input  logic               stop,
  input  logic               step,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  output logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] phase,
  output logic               busy,
  output logic               done,
  output logic               fault
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  logic [WIDTH-1:0]   q_r;
  logic [CNT_W-1:0]   rem_r;
  logic               dir_r;
  logic               busy_r;
  logic               done_r;
  logic               fault_r;
  logic               legal_s;
  logic [2*WIDTH-1:0] phase_s;

  // A Johnson word is legal when it has at most one transition between adjacent bits.
  function automatic logic ring_legal(input logic [WIDTH-1:0] v);
    int edges;
    edges = 0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (v[i] != v[i+1]) begin
        edges = edges + 1;
      end else begin
        edges = edges;
      end
    end
    return (edges <= 1);
  endfunction

  function automatic logic [WIDTH-1:0] ring_adv(input logic [WIDTH-1:0] v, input logic rev);
    if (rev) begin
      return {v[WIDTH-2:0], ~v[WIDTH-1]};
    end else begin
      return {~v[0], v[WIDTH-1:1]};
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] ring_phase(input logic [WIDTH-1:0] v, input logic ok);
    int ones;
    int idx;
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + int'(v[i]);
    end
    if (ones == 0) begin
      idx = 0;
    end else if (v[WIDTH-1]) begin
      idx = ones;
    end else begin
      idx = 2 * WIDTH - ones;
    end
    if (ok) begin
      return {{(2*WIDTH-1){1'b0}}, 1'b1} << idx;
    end else begin
      return {(2*WIDTH){1'b0}};
    end
  endfunction

  assign legal_s = ring_legal(q_r);
  assign phase_s = ring_phase(q_r, legal_s);

  // Command sequencing, ring update and illegal-pattern recovery.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      q_r     <= {WIDTH{1'b0}};
      rem_r   <= CNT_ZERO;
      dir_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (!legal_s) begin
        q_r     <= {WIDTH{1'b0}};
        fault_r <= 1'b1;
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (load) begin
              q_r <= load_val;
            end else if (start) begin
              state_r <= RUN;
              busy_r  <= 1'b1;
              rem_r   <= len;
              dir_r   <= dir;
              fault_r <= 1'b0;
            end else if (step) begin
              q_r <= ring_adv(q_r, dir);
            end else begin
              q_r <= q_r;
            end
          end
          RUN: begin
            if (stop) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              q_r <= ring_adv(q_r, dir_r);
              // rem stays at zero for a free run, so only counted runs terminate here
              if (rem_r != CNT_ZERO) begin
                rem_r <= rem_r - CNT_ONE;
                if (rem_r == CNT_ONE) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                end else begin
                  state_r <= RUN;
                end
              end else begin
                rem_r <= CNT_ZERO;
              end
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign q     = q_r;
  assign phase = phase_s;
  assign busy  = busy_r;
  assign done  = done_r;
  assign fault = fault_r;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl: directed scenarios plus random commands
// checked against a phase-index reference model.
module tb_johnson_seq_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;
  localparam int P  = 2 * W;

  logic          clk;
  logic          reset;
  logic          start;
  logic [CW-1:0] len;
  logic          dir;
  logic          stop;
  logic          step;
  logic          load;
  logic [W-1:0]  load_val;
  logic [W-1:0]  q;
  logic [P-1:0]  phase;
  logic          busy;
  logic          done;
  logic          fault;

  int checks;
  int errors;

  // reference model state: ring value plus run bookkeeping
  logic [W-1:0] m_q;
  logic         m_busy;
  logic         m_done;
  logic         m_fault;
  logic         m_dir;
  logic         m_free;
  int           m_left;

  johnson_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .dir(dir), .stop(stop),
    .step(step), .load(load), .load_val(load_val), .q(q), .phase(phase),
    .busy(busy), .done(done), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ring word at phase k: k leading ones for k<=W, else (2W-k) trailing ones
  function automatic logic [W-1:0] q_of(input int k);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) begin
      if (k <= W) v[i] = (i >= W - k);
      else        v[i] = (i < P - k);
    end
    return v;
  endfunction

  function automatic int idx_of(input logic [W-1:0] v);
    for (int k = 0; k < P; k++) if (q_of(k) == v) return k;
    return -1;
  endfunction

  function automatic logic [P-1:0] phase_of(input logic [W-1:0] v);
    logic [P-1:0] one;
    int k;
    one = 1;
    k = idx_of(v);
    if (k < 0) return '0;
    return one << k;
  endfunction

  task automatic model_reset();
    m_q = '0; m_busy = 1'b0; m_done = 1'b0; m_fault = 1'b0;
    m_dir = 1'b0; m_free = 1'b0; m_left = 0;
  endtask

  task automatic model_edge();
    int k;
    k = idx_of(m_q);
    m_done = 1'b0;
    if (k < 0) begin
      m_q = '0; m_fault = 1'b1; m_busy = 1'b0;
    end else if (!m_busy) begin
      if (load) m_q = load_val;
      else if (start) begin
        m_busy = 1'b1; m_left = int'(len); m_free = (len == 0); m_dir = dir; m_fault = 1'b0;
      end else if (step) m_q = q_of(dir ? (k + P - 1) % P : (k + 1) % P);
    end else begin
      if (stop) begin
        m_busy = 1'b0; m_done = 1'b1;
      end else begin
        m_q = q_of(m_dir ? (k + P - 1) % P : (k + 1) % P);
        if (!m_free) begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_busy = 1'b0; m_done = 1'b1; end
        end
      end
    end
  endtask

  task automatic clr_in();
    start = 1'b0; len = '0; dir = 1'b0; stop = 1'b0; step = 1'b0; load = 1'b0; load_val = '0;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr_in();
    reset = 1'b0;
    model_reset();
    #12;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (q !== 4'b0000 || phase !== 8'b0000_0001 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset: q=%b phase=%b busy=%b done=%b fault=%b, want 0000 00000001 0 0 0",
               q, phase, busy, done, fault);
    end
  endtask

  task automatic test_run_fwd();
    logic [W-1:0] exp_q [8];
    exp_q = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    clr_in(); start = 1'b1; len = 8'd8; dir = 1'b0;
    tick();
    clr_in();
    checks++;
    if (busy !== 1'b1 || q !== 4'b0000 || done !== 1'b0) begin
      errors++; $display("FAIL fwd_start: busy=%b q=%b done=%b, want 1 0000 0", busy, q, done);
    end
    for (int i = 0; i < 8; i++) begin
      logic [P-1:0] exp_ph;
      exp_ph = 8'b0000_0001 << ((i + 1) % 8);
      tick();
      checks++;
      if (q !== exp_q[i] || phase !== exp_ph || busy !== (i < 7) || done !== (i == 7)) begin
        errors++;
        $display("FAIL fwd_adv%0d: q=%b phase=%b busy=%b done=%b, want %b %b %b %b",
                 i, q, phase, busy, done, exp_q[i], exp_ph, (i < 7), (i == 7));
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL fwd_done_once: done=%b busy=%b, want 0 0", done, busy);
    end
  endtask

  task automatic test_run_rev();
    logic [W-1:0] exp_q [3];
    logic [P-1:0] exp_ph [3];
    exp_q  = '{4'b0001, 4'b0011, 4'b0111};
    exp_ph = '{8'b1000_0000, 8'b0100_0000, 8'b0010_0000};
    clr_in(); start = 1'b1; len = 8'd3; dir = 1'b1;
    tick();
    clr_in();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (q !== exp_q[i] || phase !== exp_ph[i] || done !== (i == 2) || busy !== (i < 2)) begin
        errors++;
        $display("FAIL rev_adv%0d: q=%b phase=%b done=%b busy=%b, want %b %b %b %b",
                 i, q, phase, done, busy, exp_q[i], exp_ph[i], (i == 2), (i < 2));
      end
    end
  endtask

  task automatic test_free_run_stop();
    clr_in(); load = 1'b1; load_val = 4'b0000;
    tick();
    clr_in(); start = 1'b1; len = 8'd0; dir = 1'b0;
    tick();
    clr_in();
    repeat (10) tick();
    checks++;
    if (q !== 4'b1100 || busy !== 1'b1) begin
      errors++; $display("FAIL free_run: q=%b busy=%b, want 1100 1", q, busy);
    end
    stop = 1'b1;
    tick();
    clr_in();
    checks++;
    if (q !== 4'b1100 || busy !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL stop: q=%b busy=%b done=%b, want 1100 0 1", q, busy, done);
    end
    tick();
    checks++;
    if (done !== 1'b0 || q !== 4'b1100) begin
      errors++; $display("FAIL stop_after: done=%b q=%b, want 0 1100", done, q);
    end
  endtask

  task automatic test_illegal_load();
    clr_in(); load = 1'b1; load_val = 4'b0101;
    tick();
    clr_in();
    checks++;
    if (q !== 4'b0101 || phase !== 8'b0000_0000 || fault !== 1'b0) begin
      errors++; $display("FAIL illegal_seen: q=%b phase=%b fault=%b, want 0101 00000000 0", q, phase, fault);
    end
    start = 1'b1; len = 8'd1;
    tick();
    clr_in();
    checks++;
    if (q !== 4'b0000 || fault !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL illegal_recover: q=%b fault=%b busy=%b done=%b, want 0000 1 0 0",
                         q, fault, busy, done);
    end
    start = 1'b1; len = 8'd1;
    tick();
    clr_in();
    checks++;
    if (fault !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL fault_clear: fault=%b busy=%b, want 0 1", fault, busy);
    end
    tick();
    checks++;
    if (q !== 4'b1000 || done !== 1'b1) begin
      errors++; $display("FAIL short_run: q=%b done=%b, want 1000 1", q, done);
    end
  endtask

  task automatic test_step();
    logic [W-1:0] exp_q [3];
    exp_q = '{4'b0001, 4'b0011, 4'b0111};
    clr_in(); load = 1'b1; load_val = 4'b0000;
    tick();
    for (int i = 0; i < 3; i++) begin
      clr_in(); step = 1'b1; dir = 1'b1;
      tick();
      checks++;
      if (q !== exp_q[i] || done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL step%0d: q=%b done=%b busy=%b, want %b 0 0", i, q, done, busy, exp_q[i]);
      end
    end
    clr_in(); start = 1'b1; len = 8'd2; dir = 1'b0;
    tick();
    clr_in(); step = 1'b1; load = 1'b1; load_val = 4'b0000; dir = 1'b1; start = 1'b1; len = 8'd7;
    tick();
    checks++;
    if (q !== 4'b0011 || busy !== 1'b1) begin
      errors++; $display("FAIL run_ignore1: q=%b busy=%b, want 0011 1", q, busy);
    end
    tick();
    checks++;
    if (q !== 4'b0001 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL run_ignore2: q=%b done=%b busy=%b, want 0001 1 0", q, done, busy);
    end
    clr_in();
  endtask

  task automatic test_back_to_back();
    clr_in(); start = 1'b1; len = 8'd1; dir = 1'b0;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_first: done=%b busy=%b, want 1 0", done, busy);
    end
    start = 1'b1; len = 8'd1; dir = 1'b1;
    tick();
    clr_in();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
    end
    tick();
    checks++;
    if (q !== m_q || done !== 1'b1) begin
      errors++; $display("FAIL b2b_second: q=%b done=%b, want %b 1", q, done, m_q);
    end
  endtask

  task automatic test_async_reset();
    clr_in(); load = 1'b1; load_val = 4'b0000;
    tick();
    clr_in(); start = 1'b1; len = 8'd0; dir = 1'b0;
    tick();
    clr_in();
    repeat (3) tick();
    checks++;
    if (q !== 4'b1110 || busy !== 1'b1) begin
      errors++; $display("FAIL pre_reset: q=%b busy=%b, want 1110 1", q, busy);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (q !== 4'b0000 || phase !== 8'b0000_0001 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
      errors++; $display("FAIL async_reset: q=%b phase=%b busy=%b done=%b fault=%b, want 0000 00000001 0 0 0",
                         q, phase, busy, done, fault);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (q !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset: q=%b busy=%b, want 0000 0", q, busy);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      start    = ($urandom_range(0, 3) == 0);
      len      = CW'($urandom_range(0, 6));
      dir      = $urandom_range(0, 1) != 0;
      stop     = ($urandom_range(0, 7) == 0);
      step     = ($urandom_range(0, 2) == 0);
      load     = ($urandom_range(0, 9) == 0);
      load_val = W'($urandom);
      tick();
      checks++;
      if (q !== m_q || phase !== phase_of(m_q) || busy !== m_busy || done !== m_done || fault !== m_fault) begin
        errors++;
        $display("FAIL random%0d: q=%b phase=%b busy=%b done=%b fault=%b, want %b %b %b %b %b",
                 n, q, phase, busy, done, fault, m_q, phase_of(m_q), m_busy, m_done, m_fault);
      end
    end
    clr_in();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_run_fwd();
    test_run_rev();
    test_free_run_stop();
    test_illegal_load();
    test_step();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
